// File: rtl/btn_event_arbiter.sv
// Button event arbiter: latches single-cycle press pulses as pending requests and
// serialises them round-robin, with a minimum grant spacing, into a FWFT event FIFO.
module btn_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 100_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BTN-1:0]              press,
  output logic                          ev_valid,
  output logic [$clog2(N_BTN)-1:0]      ev_id,
  input  logic                          ev_ready,
  output logic [N_BTN-1:0]              pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int IDW = $clog2(N_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  // Saturating countdown: parks at zero once the spacing window has elapsed.
  function automatic logic [GW-1:0] sat_dec(input logic [GW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [IDW-1:0]   rr_ptr;
  logic [GW-1:0]    gap_cnt;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [IDW-1:0]   mem [FIFO_DEPTH];

  logic             grant_ok;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] lost;
  logic             pop;
  int               cand;

  assign grant_ok = (|pending) && (fifo_count < (PW+1)'(FIFO_DEPTH)) && (gap_cnt == '0);

  // Scan downward so the last hit is the one closest to rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (grant_ok) begin
      for (int k = N_BTN - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr) + k) % N_BTN;
        if (pending[cand]) begin
          grant_vld = 1'b1;
          grant_idx = IDW'(cand);
        end
      end
    end
  end

  assign grant_vec = grant_vld ? (N_BTN'(1) << grant_idx) : '0;
  assign lost      = press & pending & ~grant_vec;
  assign ev_valid  = (fifo_count != '0);
  assign ev_id     = ev_valid ? mem[rd_ptr] : '0;
  assign pop       = ev_valid && ev_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      rr_ptr     <= '0;
      gap_cnt    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      pending  <= (pending & ~grant_vec) | press;
      overflow <= (|lost) | (overflow & ~clr_overflow);
      if (grant_vld) begin
        rr_ptr  <= (int'(grant_idx) == N_BTN - 1) ? '0 : grant_idx + 1'b1;
        gap_cnt <= GAP_LOAD;
        wr_ptr  <= wr_ptr + 1'b1;
      end else begin
        gap_cnt <= sat_dec(gap_cnt);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant_vld, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage carries data only; occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (grant_vld) mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Randomised and directed bench for btn_event_arbiter against a queue-based
// reference model that tracks grant times rather than a countdown register.
module tb_btn_event_arbiter;
  localparam int N   = 4;
  localparam int DEP = 4;
  localparam int GAP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] press;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic         ev_ready;
  logic [N-1:0] pending;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic         clr_overflow;

  btn_event_arbiter #(.N_BTN(N), .FIFO_DEPTH(DEP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .press(press), .ev_valid(ev_valid), .ev_id(ev_id),
    .ev_ready(ev_ready), .pending(pending), .fifo_count(fifo_count),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend [N];
  int m_q [$];
  int m_rr;
  int m_last;
  int m_cyc;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_q.delete();
    m_rr   = 0;
    m_last = -1000;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic rdy, input logic clr, input logic r);
    int  g;
    bit  any;
    bit  lost;
    if (r) begin
      model_reset();
    end else begin
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      g = -1;
      if (any && m_q.size() < DEP && (m_cyc - m_last) >= GAP) begin
        for (int k = 0; k < N && g < 0; k++)
          if (m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g);
        m_rr   = (g + 1) % N;
        m_last = m_cyc;
      end
      lost = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (p[i] && m_pend[i] && g != i) lost = 1'b1;
        m_pend[i] = (m_pend[i] && g != i) || p[i];
      end
      if (lost) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic compare();
    logic [N-1:0] ep;
    for (int i = 0; i < N; i++) ep[i] = m_pend[i];
    chk("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
    chk("ev_id", 32'(ev_id), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("pending", 32'(pending), 32'(ep));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input logic [N-1:0] p, input logic rdy, input logic clr, input logic r);
    press = p; ev_ready = rdy; clr_overflow = clr; rst = r;
    @(negedge clk);
    compare();
    model_step(p, rdy, clr, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle('0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; press = '0; ev_ready = 1'b0; clr_overflow = 1'b0;
    m_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_id", 32'(ev_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    cycle('0, 1'b0, 1'b0, 1'b0);

    // Single press: valid two edges after the press, for one cycle
    idle(4, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("single_pend", 32'(pending), 32'b0100);
    cycle('0, 1'b1, 1'b0, 1'b0);
    chk("single_vld", 32'(ev_valid), 32'd1);
    chk("single_id", 32'(ev_id), 32'd2);
    cycle('0, 1'b1, 1'b0, 1'b0);
    chk("single_vld_gone", 32'(ev_valid), 32'd0);
    chk("single_ovf", 32'(overflow), 32'd0);

    // Simultaneous presses from rr_ptr=0, consumer stalled
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    idle(4 * GAP + 2, 1'b0);
    chk("sim_count", 32'(fifo_count), 32'd4);
    chk("sim_pending", 32'(pending), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("sim_pop_id", 32'(ev_id), 32'(k));
      cycle('0, 1'b1, 1'b0, 1'b0);
    end
    chk("sim_empty", 32'(ev_valid), 32'd0);

    // Full FIFO then coalescing on button 1
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    idle(4 * GAP + 2, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("full_pend1", 32'(pending[1]), 32'd1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("refill_count", 32'(fifo_count), 32'd4);
    chk("refill_pend", 32'(pending), 32'd0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Reset mid-operation, presses in reset cycle ignored
    cycle(4'b0101, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0, 1'b0);
    idle(GAP * 2 + 1, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(ev_valid), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'd0);
    cycle(4'b1010, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first", 32'(ev_id), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] p;
      for (int b = 0; b < N; b++) p[b] = ($urandom_range(0, 7) == 0);
      cycle(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
